// File: rtl/sd_job_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sd_job_scheduler: sequences the sphere-decoder core over received jobs.  |
// | Optional macro SD_SCHED_CYCLE_COUNT_EN adds the OutCycles result port.   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module sd_job_scheduler #(
  parameter int WIDTH       = 32,
  parameter int KICK_CYCLES = 2,
  parameter int MAX_CYCLES  = 8191,
  parameter int CW          = 13
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                CfgWr,
  input  logic [4:0]          CfgAddr,
  input  logic [WIDTH-1:0]    CfgData,
  output logic                CfgReady,
  input  logic                InValid,
  output logic                InReady,
  input  logic [WIDTH-1:0]    InWord,
  output logic [8*WIDTH-1:0]  CoreY,
  output logic [20*WIDTH-1:0] CoreR,
  output logic                CoreRst_n,
  input  logic                CoreOutputReady,
  input  logic [11:0]         CoreSBest,
  output logic                OutValid,
  input  logic                OutReady,
  output logic [11:0]         OutS,
  output logic                OutErr
`ifdef SD_SCHED_CYCLE_COUNT_EN
  ,
  output logic [CW-1:0]       OutCycles
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_KICK = 3'd2,
    ST_RUN  = 3'd3,
    ST_OUT  = 3'd4
  } state_t;

  localparam logic [CW-1:0] c_one       = CW'(1);
  localparam logic [CW-1:0] c_max       = CW'(MAX_CYCLES);
  localparam logic [CW-1:0] c_kick_last = CW'(KICK_CYCLES - 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_y [8];
  logic [WIDTH-1:0] r_r [20];
  logic [2:0]       r_wcnt;
  logic [CW-1:0]    r_cyc;
  logic             r_core_rst_n;
  logic             r_in_ready;
  logic [11:0]      r_out_s;
  logic             r_out_err;
  logic             w_in_xfer;
  logic             w_cfg_ready;
  logic             w_out_valid;
  logic             w_done;
  logic             w_timeout;
  logic [CW-1:0]    w_cyc_now;

  // r_cyc counts KICK cycles in KICK, and completed RUN cycles in RUN
  assign w_cyc_now = r_cyc + c_one;
  assign w_in_xfer = InValid & r_in_ready;
  assign w_done    = (r_state == ST_RUN) && CoreOutputReady && (r_cyc != '0);
  assign w_timeout = (r_state == ST_RUN) && (w_cyc_now == c_max);

  always_comb begin
    w_next      = r_state;
    w_cfg_ready = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cfg_ready = 1'b1;
        if (w_in_xfer) w_next = ST_LOAD;
      end
      ST_LOAD: begin
        w_cfg_ready = 1'b1;
        if (w_in_xfer && (r_wcnt == 3'd7)) w_next = ST_KICK;
      end
      ST_KICK: begin
        if (r_cyc == c_kick_last) w_next = ST_RUN;
      end
      ST_RUN: begin
        if (w_done || w_timeout) w_next = ST_OUT;
      end
      ST_OUT: begin
        w_out_valid = 1'b1;
        if (OutReady) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < 8; i++)  r_y[i] <= '0;
      for (int i = 0; i < 20; i++) r_r[i] <= '0;
      r_wcnt       <= '0;
      r_cyc        <= '0;
      r_core_rst_n <= 1'b0;
      r_in_ready   <= 1'b0;
      r_out_s      <= '0;
      r_out_err    <= 1'b0;
    end else begin
      r_core_rst_n <= (w_next == ST_RUN);
      r_in_ready   <= (w_next == ST_IDLE) || (w_next == ST_LOAD);
      if (w_in_xfer) begin
        r_y[r_wcnt] <= InWord;
        r_wcnt      <= r_wcnt + 3'd1;
      end
      if (CfgWr && w_cfg_ready && (CfgAddr < 5'd20)) r_r[CfgAddr] <= CfgData;
      case (r_state)
        ST_KICK: r_cyc <= (w_next == ST_RUN) ? '0 : w_cyc_now;
        ST_RUN:  r_cyc <= w_cyc_now;
        default: r_cyc <= '0;
      endcase
      // Done takes priority over a timeout landing on the same cycle
      if (w_done) begin
        r_out_s   <= CoreSBest;
        r_out_err <= 1'b0;
      end else if (w_timeout) begin
        r_out_s   <= '0;
        r_out_err <= 1'b1;
      end
    end
  end

`ifdef SD_SCHED_CYCLE_COUNT_EN
  logic [CW-1:0] r_out_cycles;
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)                  r_out_cycles <= '0;
    else if (w_done || w_timeout) r_out_cycles <= w_cyc_now;
  end
  assign OutCycles = r_out_cycles;
`endif

  for (genvar i = 0; i < 8; i++) begin : g_core_y
    assign CoreY[i*WIDTH +: WIDTH] = r_y[i];
  end

  for (genvar i = 0; i < 20; i++) begin : g_core_r
    assign CoreR[i*WIDTH +: WIDTH] = r_r[i];
  end

  assign CfgReady  = w_cfg_ready;
  assign InReady   = r_in_ready;
  assign CoreRst_n = r_core_rst_n;
  assign OutValid  = w_out_valid;
  assign OutS      = r_out_s;
  assign OutErr    = r_out_err;

endmodule
`default_nettype wire

// File: tb/tb_sd_job_scheduler.sv
`default_nettype none
// Directed bench for sd_job_scheduler; the bench itself models the core
// as a stub that raises OutputReady from a chosen RUN cycle onward.
module tb_sd_job_scheduler;
  localparam int W    = 32;
  localparam int K    = 2;
  localparam int MAXC = 100;
  localparam int CWP  = 13;

  logic            Clk = 1'b0;
  logic            Reset;
  logic            CfgWr;
  logic [4:0]      CfgAddr;
  logic [W-1:0]    CfgData;
  logic            CfgReady;
  logic            InValid;
  logic            InReady;
  logic [W-1:0]    InWord;
  logic [8*W-1:0]  CoreY;
  logic [20*W-1:0] CoreR;
  logic            CoreRst_n;
  logic            CoreOutputReady;
  logic [11:0]     CoreSBest;
  logic            OutValid;
  logic            OutReady;
  logic [11:0]     OutS;
  logic            OutErr;
`ifdef SD_SCHED_CYCLE_COUNT_EN
  logic [CWP-1:0]  OutCycles;
`endif

  int errors = 0;
  int checks = 0;
  int stub_from = 0;
  int run_cnt = 0;
  int cfg_vals [20] = '{-95899, 4756, -35369, -20776, 54987, 13310, 84358, -92207, 4353, 39784,
                        0, 23655, -18166, 4132, 0, 40171, 2411, 0, 5122, 0};
  int job1 [8] = '{90956, 68929, -648, 34232, 865, -7996, -93077, -24206};
  int job2 [8] = '{-1, 7, 123456, -42, 0, 99, -77777, 31};
  int cur_words [8];
  logic [20*W-1:0] exp_r;
  logic [8*W-1:0]  exp_y;

  sd_job_scheduler #(.WIDTH(W), .KICK_CYCLES(K), .MAX_CYCLES(MAXC), .CW(CWP)) dut (
    .Clk(Clk), .Reset(Reset), .CfgWr(CfgWr), .CfgAddr(CfgAddr), .CfgData(CfgData),
    .CfgReady(CfgReady), .InValid(InValid), .InReady(InReady), .InWord(InWord),
    .CoreY(CoreY), .CoreR(CoreR), .CoreRst_n(CoreRst_n), .CoreOutputReady(CoreOutputReady),
    .CoreSBest(CoreSBest), .OutValid(OutValid), .OutReady(OutReady), .OutS(OutS),
    .OutErr(OutErr)
`ifdef SD_SCHED_CYCLE_COUNT_EN
    , .OutCycles(OutCycles)
`endif
  );

  always #5 Clk = ~Clk;

  // Stub core: run_cnt is the number of completed RUN cycles
  always @(posedge Clk) run_cnt <= CoreRst_n ? run_cnt + 1 : 0;
  assign CoreOutputReady = CoreRst_n && (stub_from != 0) && (run_cnt + 1 >= stub_from);

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic cfg_write(input logic [4:0] a, input logic [W-1:0] d);
    CfgWr = 1'b1; CfgAddr = a; CfgData = d;
    tick();
    CfgWr = 1'b0;
  endtask

  task automatic build_exp_y();
    for (int i = 0; i < 8; i++) exp_y[i*W +: W] = cur_words[i];
  endtask

  task automatic send_job(input int gap);
    int b;
    for (int i = 0; i < 8; i++) begin
      InValid = 1'b1; InWord = cur_words[i]; b = 0;
      while (!InReady && b < 50) begin tick(); b++; end
      checks++;
      if (!InReady) begin
        errors++;
        $display("FAIL send_word%0d: InReady=%b required 1 within 50 cycles", i, InReady);
      end
      tick();
      InValid = 1'b0;
      if (i != 7) repeat (gap) tick();
    end
  endtask

  // lat = edges from word-7 transfer to OutValid; runs = cycles with CoreRst_n high
  task automatic wait_result(output int lat, output int runs);
    lat = 0; runs = 0;
    while (lat < 400) begin
      tick(); lat++;
      if (OutValid) break;
      if (CoreRst_n) runs++;
    end
    checks++;
    if (!OutValid) begin
      errors++;
      $display("FAIL wait_result: OutValid=%b required 1 within 400 cycles", OutValid);
    end
  endtask

  task automatic accept();
    OutReady = 1'b1;
    tick();
    OutReady = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    tick();
    checks++; if (CoreRst_n !== 1'b0) begin errors++; $display("FAIL rst_corerst: got %b want 0", CoreRst_n); end
    checks++; if (InReady !== 1'b0)   begin errors++; $display("FAIL rst_inready: got %b want 0", InReady); end
    checks++; if (CfgReady !== 1'b1)  begin errors++; $display("FAIL rst_cfgready: got %b want 1", CfgReady); end
    checks++; if (OutValid !== 1'b0)  begin errors++; $display("FAIL rst_outvalid: got %b want 0", OutValid); end
    checks++; if (OutS !== 12'h000 || OutErr !== 1'b0) begin errors++; $display("FAIL rst_out: OutS=%h OutErr=%b want 000/0", OutS, OutErr); end
    checks++; if (CoreY !== '0 || CoreR !== '0) begin errors++; $display("FAIL rst_regs: CoreY/CoreR not zero"); end
    tick();
    Reset = 1'b1;
    tick();
    checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL idle_inready: got %b want 1", InReady); end
  endtask

  task automatic test_cfg();
    for (int i = 0; i < 20; i++) begin
      cfg_write(5'(i), cfg_vals[i]);
      exp_r[i*W +: W] = cfg_vals[i];
    end
    checks++; if (CoreR !== exp_r) begin errors++; $display("FAIL cfg_load: CoreR=%h want %h", CoreR, exp_r); end
    cfg_write(5'd25, 32'hDEAD_BEEF);
    checks++; if (CoreR !== exp_r) begin errors++; $display("FAIL cfg_addr25: CoreR=%h want %h", CoreR, exp_r); end
    cfg_write(5'd3, 32'd5);
    checks++; if (CoreR[3*W +: W] !== 32'd5) begin errors++; $display("FAIL cfg_addr3: R3_real=%0d want 5", CoreR[3*W +: W]); end
    cfg_write(5'd3, cfg_vals[3]);
    checks++; if (CoreR !== exp_r) begin errors++; $display("FAIL cfg_restore: CoreR=%h want %h", CoreR, exp_r); end
  endtask

  task automatic test_nominal();
    int lat, runs;
    stub_from = 5; CoreSBest = 12'hE8C;
    cur_words = job1; build_exp_y();
    send_job(1);
    checks++; if (CoreY !== exp_y) begin errors++; $display("FAIL nom_corey: CoreY=%h want %h", CoreY, exp_y); end
    checks++; if (CfgReady !== 1'b0 || InReady !== 1'b0) begin errors++; $display("FAIL nom_kick_ready: CfgReady=%b InReady=%b want 0/0", CfgReady, InReady); end
    CfgWr = 1'b1; CfgAddr = 5'd3; CfgData = 32'd5;
    wait_result(lat, runs);
    CfgWr = 1'b0;
    checks++; if (lat + 1 !== K + 5 + 1) begin errors++; $display("FAIL nom_latency: got %0d want %0d", lat + 1, K + 6); end
    checks++; if (runs !== 5) begin errors++; $display("FAIL nom_runs: got %0d want 5", runs); end
    checks++; if (OutS !== 12'hE8C || OutErr !== 1'b0) begin errors++; $display("FAIL nom_result: OutS=%h OutErr=%b want E8C/0", OutS, OutErr); end
    tick();
    checks++; if (CoreR !== exp_r) begin errors++; $display("FAIL nom_cfg_gated: CoreR=%h want %h", CoreR, exp_r); end
    checks++; if (OutValid !== 1'b1 || OutS !== 12'hE8C) begin errors++; $display("FAIL nom_hold: OutValid=%b OutS=%h want 1/E8C", OutValid, OutS); end
    accept();
    checks++; if (OutValid !== 1'b0 || InReady !== 1'b1) begin errors++; $display("FAIL nom_release: OutValid=%b InReady=%b want 0/1", OutValid, InReady); end
  endtask

  task automatic test_timeout();
    int lat, runs;
    stub_from = 0; CoreSBest = 12'hFFF;
    cur_words = job1;
    send_job(0);
    wait_result(lat, runs);
    checks++; if (runs !== MAXC) begin errors++; $display("FAIL to_runs: got %0d want %0d", runs, MAXC); end
    checks++; if (lat + 1 !== K + MAXC + 1) begin errors++; $display("FAIL to_latency: got %0d want %0d", lat + 1, K + MAXC + 1); end
    checks++; if (OutS !== 12'h000 || OutErr !== 1'b1) begin errors++; $display("FAIL to_result: OutS=%h OutErr=%b want 000/1", OutS, OutErr); end
`ifdef SD_SCHED_CYCLE_COUNT_EN
    checks++; if (OutCycles !== CWP'(MAXC)) begin errors++; $display("FAIL to_cycles: got %0d want %0d", OutCycles, MAXC); end
`endif
    accept();
  endtask

  task automatic test_collision();
    int lat, runs;
    stub_from = MAXC; CoreSBest = 12'h123;
    send_job(0);
    wait_result(lat, runs);
    checks++; if (runs !== MAXC) begin errors++; $display("FAIL col_runs: got %0d want %0d", runs, MAXC); end
    checks++; if (OutS !== 12'h123 || OutErr !== 1'b0) begin errors++; $display("FAIL col_result: OutS=%h OutErr=%b want 123/0", OutS, OutErr); end
    accept();
  endtask

  task automatic test_min_latency();
    int lat, runs;
    stub_from = 1; CoreSBest = 12'h5A5;
    send_job(0);
    wait_result(lat, runs);
    checks++; if (lat + 1 !== K + 3) begin errors++; $display("FAIL min_latency: got %0d want %0d", lat + 1, K + 3); end
    checks++; if (OutS !== 12'h5A5 || OutErr !== 1'b0) begin errors++; $display("FAIL min_result: OutS=%h OutErr=%b want 5A5/0", OutS, OutErr); end
`ifdef SD_SCHED_CYCLE_COUNT_EN
    checks++; if (OutCycles !== CWP'(2)) begin errors++; $display("FAIL min_cycles: got %0d want 2", OutCycles); end
`endif
    accept();
  endtask

  task automatic test_back_to_back();
    int lat, runs;
    stub_from = 3; CoreSBest = 12'h3C7;
    cur_words = job1; build_exp_y();
    send_job(0);
    wait_result(lat, runs);
    InValid = 1'b1; InWord = job2[0];
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if (OutValid !== 1'b1 || OutS !== 12'h3C7 || InReady !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold c%0d: OutValid=%b OutS=%h InReady=%b want 1/3C7/0", c, OutValid, OutS, InReady);
      end
    end
    checks++; if (CoreY !== exp_y) begin errors++; $display("FAIL bp_corey: CoreY=%h want %h", CoreY, exp_y); end
    stub_from = 4; CoreSBest = 12'h111;
    accept();
    checks++; if (OutValid !== 1'b0 || InReady !== 1'b1) begin errors++; $display("FAIL bp_release: OutValid=%b InReady=%b want 0/1", OutValid, InReady); end
    cur_words = job2; build_exp_y();
    send_job(0);
    checks++; if (CoreY !== exp_y) begin errors++; $display("FAIL bp_job2_corey: CoreY=%h want %h", CoreY, exp_y); end
    wait_result(lat, runs);
    checks++; if (runs !== 4 || OutS !== 12'h111 || OutErr !== 1'b0) begin errors++; $display("FAIL bp_job2: runs=%0d OutS=%h OutErr=%b want 4/111/0", runs, OutS, OutErr); end
    accept();
  endtask

  task automatic test_reset_mid_run();
    int b, lat, runs;
    stub_from = 0;
    cur_words = job1;
    send_job(0);
    b = 0;
    while (!CoreRst_n && b < 20) begin tick(); b++; end
    repeat (3) tick();
    checks++; if (CoreRst_n !== 1'b1) begin errors++; $display("FAIL mid_in_run: CoreRst_n=%b want 1", CoreRst_n); end
    #2 Reset = 1'b0;
    #1 Reset = 1'b1;
    #1;
    checks++; if (CoreRst_n !== 1'b0 || OutValid !== 1'b0) begin errors++; $display("FAIL mid_outputs: CoreRst_n=%b OutValid=%b want 0/0", CoreRst_n, OutValid); end
    checks++; if (CfgReady !== 1'b1 || CoreR !== '0 || CoreY !== '0) begin errors++; $display("FAIL mid_idle: CfgReady=%b regs not cleared", CfgReady); end
    tick();
    stub_from = 6; CoreSBest = 12'h2B4;
    cur_words = job2; build_exp_y();
    send_job(2);
    checks++; if (CoreY !== exp_y) begin errors++; $display("FAIL mid_corey: CoreY=%h want %h", CoreY, exp_y); end
    wait_result(lat, runs);
    checks++; if (runs !== 6 || OutS !== 12'h2B4 || OutErr !== 1'b0) begin errors++; $display("FAIL mid_job: runs=%0d OutS=%h OutErr=%b want 6/2B4/0", runs, OutS, OutErr); end
    accept();
  endtask

  initial begin
    CfgWr = 1'b0; CfgAddr = '0; CfgData = '0;
    InValid = 1'b0; InWord = '0; OutReady = 1'b0; CoreSBest = '0;
    test_reset();
    test_cfg();
    test_nominal();
    test_timeout();
    test_collision();
    test_min_latency();
    test_back_to_back();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
